// File: rtl/operand_unpacker_pkg.sv
// Operand class definitions shared by the FPU front end.
// Holds the class encoding, field constants and the IEEE-754 single
// precision classification rule used by stage 1 of operand_unpacker.
package operand_class;

    typedef enum logic [2:0] {
        ZERO     = 3'd0,
        DENORMAL = 3'd1,
        NORMAL   = 3'd2,
        INFINITY = 3'd3,
        QNAN     = 3'd4,
        SNAN     = 3'd5
    } operand_class_t;

    localparam logic [7:0] EXP_MAX   = 8'hFF;
    localparam int         QUIET_BIT = 22;

    // Classify a packed single from its biased exponent and stored fraction.
    function automatic operand_class_t classify(input logic [7:0]  exp_f,
                                                input logic [22:0] frac_f);
        operand_class_t cls;
        if (exp_f == EXP_MAX) begin
            if (frac_f == 23'd0)
                cls = INFINITY;
            else if (frac_f[QUIET_BIT])
                cls = QNAN;
            else
                cls = SNAN;
        end else if (exp_f == 8'd0) begin
            cls = (frac_f == 23'd0) ? ZERO : DENORMAL;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/operand_unpacker_leading_zero_counter.sv
// Leading-zero counter for a 24-bit fraction. Purely combinational.
// An all-zero input reports 24.
module leading_zero_counter (
    input  logic [23:0] i_value,
    output logic [4:0]  o_count
);

    // Scan upward so the most significant set bit decides the count.
    always_comb begin
        o_count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (i_value[i])
                o_count = 5'(23 - i);
        end
    end

endmodule

// File: rtl/operand_unpacker.sv
// FPU operand unpacker: splits two packed IEEE-754 singles into sign,
// biased exponent and hidden-bit fraction, classifies them (stage 1) and
// normalizes denormals to a leading 1 (stage 2) behind a two-stage
// valid/ready pipeline. EXP_WIDTH must be at least 10.
// Optional build macro OPERAND_UNPACKER_DAZ_EN: denormal inputs are treated
// as ZERO (fraction and normalized values cleared, sign and raw exponent
// kept) and no leading-zero counter is built.
module operand_unpacker
    import operand_class::*;
#(
    parameter int EXP_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_operand_a,
    input  logic [31:0]          in_operand_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 operand_sign_a,
    output logic                 operand_sign_b,
    output logic [7:0]           operand_exponent_a,
    output logic [7:0]           operand_exponent_b,
    output logic [23:0]          operand_fraction_a,
    output logic [23:0]          operand_fraction_b,
    output logic [EXP_WIDTH-1:0] norm_exponent_a,
    output logic [EXP_WIDTH-1:0] norm_exponent_b,
    output logic [23:0]          norm_fraction_a,
    output logic [23:0]          norm_fraction_b,
    output logic [2:0]           operand_class_a,
    output logic [2:0]           operand_class_b
);

    typedef struct packed {
        logic           sign;
        logic [7:0]     exp;
        logic [22:0]    frac;
        operand_class_t cls;
    } split_t;

    typedef struct packed {
        logic                 sign;
        logic [7:0]           exp;
        logic [23:0]          frac;
        logic [EXP_WIDTH-1:0] nexp;
        logic [23:0]          nfrac;
        operand_class_t       cls;
    } unpacked_t;

    // Stage-1 view of a packed operand; under DAZ a denormal collapses to
    // ZERO here so stage 2 never sees it.
    function automatic split_t split(input logic [31:0] op);
        split_t s;
        s.sign = op[31];
        s.exp  = op[30:23];
        s.frac = op[22:0];
        s.cls  = classify(op[30:23], op[22:0]);
`ifdef OPERAND_UNPACKER_DAZ_EN
        if (s.cls == DENORMAL) begin
            s.cls  = ZERO;
            s.frac = 23'd0;
        end
`endif
        return s;
    endfunction

    // Stage-2 result for one operand given its leading-zero count.
    function automatic unpacked_t normalize(input split_t s, input logic [4:0] lz);
        unpacked_t u;
        u.sign  = s.sign;
        u.exp   = s.exp;
        u.frac  = {(s.exp != 8'd0), s.frac};
        u.cls   = s.cls;
        u.nexp  = '0;
        u.nfrac = '0;
        case (s.cls)
            ZERO: begin
                u.nexp  = '0;
                u.nfrac = '0;
            end
            DENORMAL: begin
                u.nfrac = u.frac << lz;
                u.nexp  = EXP_WIDTH'(1) - EXP_WIDTH'(lz);
            end
            default: begin
                u.nfrac = u.frac;
                u.nexp  = EXP_WIDTH'(s.exp);
            end
        endcase
        return u;
    endfunction

    logic      r_s1_valid;
    logic      r_s2_valid;
    logic      w_s1_load;
    logic      w_s2_load;
    split_t    r_s1_a;
    split_t    r_s1_b;
    split_t    w_split_a;
    split_t    w_split_b;
    logic [4:0] w_lz_a;
    logic [4:0] w_lz_b;
    unpacked_t w_norm_a;
    unpacked_t w_norm_b;
    unpacked_t r_s2_a;
    unpacked_t r_s2_b;

    // A stage loads when empty or when its current contents leave this cycle.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;

    assign w_split_a = split(in_operand_a);
    assign w_split_b = split(in_operand_b);

`ifdef OPERAND_UNPACKER_DAZ_EN
    assign w_lz_a = 5'd0;
    assign w_lz_b = 5'd0;
`else
    leading_zero_counter u_lzc_a (
        .i_value ({1'b0, r_s1_a.frac}),
        .o_count (w_lz_a)
    );

    leading_zero_counter u_lzc_b (
        .i_value ({1'b0, r_s1_b.frac}),
        .o_count (w_lz_b)
    );
`endif

    assign w_norm_a = normalize(r_s1_a, w_lz_a);
    assign w_norm_b = normalize(r_s1_b, w_lz_b);

    // Stage occupancy bits; reset drops every in-flight pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_load)
                r_s1_valid <= in_valid;
            if (w_s2_load)
                r_s2_valid <= r_s1_valid;
        end
    end

    // Stage-1 field capture; contents are only meaningful while r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_s1_load && in_valid) begin
            r_s1_a <= w_split_a;
            r_s1_b <= w_split_b;
        end
    end

    // Stage-2 output registers; held while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_a <= '0;
            r_s2_b <= '0;
        end else if (w_s2_load && r_s1_valid) begin
            r_s2_a <= w_norm_a;
            r_s2_b <= w_norm_b;
        end
    end

    assign operand_sign_a     = r_s2_a.sign;
    assign operand_sign_b     = r_s2_b.sign;
    assign operand_exponent_a = r_s2_a.exp;
    assign operand_exponent_b = r_s2_b.exp;
    assign operand_fraction_a = r_s2_a.frac;
    assign operand_fraction_b = r_s2_b.frac;
    assign norm_exponent_a    = r_s2_a.nexp;
    assign norm_exponent_b    = r_s2_b.nexp;
    assign norm_fraction_a    = r_s2_a.nfrac;
    assign norm_fraction_b    = r_s2_b.nfrac;
    assign operand_class_a    = r_s2_a.cls;
    assign operand_class_b    = r_s2_b.cls;

endmodule

// File: doc/operand_unpacker.md
Name: operand_unpacker

Overview:
- Front end of the FPU; the inverse of result assembly.
- Accepts two packed IEEE-754 single-precision operands and splits each into sign, biased exponent and 24-bit fraction with the hidden bit restored.
- Classifies each operand and produces a normalized exponent/fraction pair, with denormals left-shifted to a leading 1.
- Two-stage valid/ready pipeline between the issue queue and the execution units.

Parameters:
- EXP_WIDTH, 10, width of the signed normalized exponent outputs. Must be ≥10.

Ports:
- clk  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  unpacker can accept
- in_operand_a  input  32  packed operand A
- in_operand_b  input  32  packed operand B
- out_valid  output  1  unpacked pair valid
- out_ready  input  1  consumer accepts
- operand_sign_a/_b  output  1  sign bit
- operand_exponent_a/_b  output  8  raw biased exponent field
- operand_fraction_a/_b  output  24  {hidden bit, fraction[22:0]}; hidden bit = (exponent != 0)
- norm_exponent_a/_b  output  EXP_WIDTH  two's-complement biased exponent after normalization
- norm_fraction_a/_b  output  24  fraction with MSB = 1 (all zeros for zero class)
- operand_class_a/_b  output  3  operand_class::operand_class_t

Behaviour:
- Reset (async assert, sync release): both stage-valid bits cleared; out_valid=0; all data outputs 0; operand_class = ZERO.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. Latency is exactly 2 cycles with no stalls. Throughput is 1 pair/cycle.
- Stage 1 (split/classify):
  - Register fields.
  - Class priority:
    - exp==255, frac!=0, frac[22]=1 → QNAN
    - exp==255, frac!=0, frac[22]=0 → SNAN
    - exp==255, frac==0 → INFINITY
    - exp==0, frac==0 → ZERO
    - exp==0, frac!=0 → DENORMAL
    - otherwise → NORMAL
- Stage 2 (normalize):
  - DENORMAL: lz = leading zeros of the 24-bit {0, frac}, range 1..23. norm_fraction = {0, frac} << lz. norm_exponent = 1 - lz, sign-extended to EXP_WIDTH.
  - NORMAL, INFINITY, QNAN, SNAN: norm_fraction = operand_fraction; norm_exponent = zero-extended exponent.
  - ZERO: norm_exponent = 0, norm_fraction = 0.
- Flow control:
  - Each stage loads when it is empty or when its contents move on in the same cycle; otherwise it holds.
  - in_ready = !s1_valid || (!s2_valid || out_ready). in_ready is combinational from out_ready; no skid buffer.
  - Simultaneous accept and emit when full: both occur and nothing is lost.
  - Outputs stay stable while out_valid && !out_ready.
- Data registers need no reset beyond the output values listed above. Valid bits are always reset.
- Reset mid-operation discards all in-flight pairs. The first pair accepted after release emerges 2 cycles later.

Optional Feature:
- Macro: OPERAND_UNPACKER_DAZ_EN (denormals-are-zero).
- Defined: DENORMAL inputs are classed ZERO, with operand_fraction, norm_fraction and norm_exponent all 0. Sign and raw exponent are kept. The leading-zero counter is not instantiated.
- Undefined: full denormal normalization as above.

Decomposition:
- Package operand_class:
  - typedef enum logic [2:0] operand_class_t {ZERO, DENORMAL, NORMAL, INFINITY, QNAN, SNAN}
  - constants EXP_MAX=8'hFF, QUIET_BIT=22
- Sub-module leading_zero_counter: 24-bit input, 5-bit count, purely combinational. Instantiated once per operand in stage 2.

Test Plan:
- A=0x3F800000, B=0xBF800000 → exactly 2 cycles later both NORMAL; exp 0x7F; fraction 0x800000; norm_exponent 0x07F; signs 0 and 1.
- A=0x00000001, B=0x00400000 → DENORMAL. A: norm_fraction 0x800000, norm_exponent 10'h3EA (−22). B: norm_fraction 0x800000, norm_exponent 10'h000 (1−1).
- A=0x7FC00000, B=0x7F800001 → QNAN and SNAN. Then A=0xFF800000, B=0x00000000 → INFINITY with sign 1, and ZERO.
- Back-to-back 4 pairs with out_ready held low for cycles 2–5 → 2 pairs accepted, then in_ready=0. After out_ready rises, all 4 emerge in order with outputs stable during the stall.
- reset_n pulsed low with 2 pairs in flight → out_valid=0 immediately, outputs 0. A pair sent after release emerges at +2 cycles and the stale pairs never appear.
- With OPERAND_UNPACKER_DAZ_EN: A=0x80000001 → ZERO, sign 1, operand_fraction 0, norm_exponent 0.
